// File: rtl/lfsr64_pkg.sv
// Shared LFSR definitions used by the lfsr64 generator and lfsr64_checker.
// Keeping the next-state function here means the generator and the checker
// always agree on the sequence.
package lfsr64_pkg;

    localparam int LFSR_W = 64;

    // Feedback taps: bits 63, 62, 60 and 59.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // One LFSR step: shift left, feed the XOR of the tap bits into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr64_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr64_checker_popcount.sv
// popcount64: combinational adder tree counting the set bits of a 64-bit word.
// Only present when LFSR_CHK_BITERR_EN is defined, since that is the only
// configuration in which the checker uses it.
`ifdef LFSR_CHK_BITERR_EN
module popcount64 (
    input  logic [63:0] din,
    output logic [6:0]  count
);

    logic [1:0] lvl1 [32];
    logic [2:0] lvl2 [16];
    logic [3:0] lvl3 [8];
    logic [4:0] lvl4 [4];
    logic [5:0] lvl5 [2];

    // Each level adds neighbouring partial sums, one bit wider than the last.
    for (genvar gi = 0; gi < 32; gi++) begin : g_lvl1
        assign lvl1[gi] = {1'b0, din[2*gi]} + {1'b0, din[2*gi+1]};
    end
    for (genvar gi = 0; gi < 16; gi++) begin : g_lvl2
        assign lvl2[gi] = {1'b0, lvl1[2*gi]} + {1'b0, lvl1[2*gi+1]};
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_lvl3
        assign lvl3[gi] = {1'b0, lvl2[2*gi]} + {1'b0, lvl2[2*gi+1]};
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_lvl4
        assign lvl4[gi] = {1'b0, lvl3[2*gi]} + {1'b0, lvl3[2*gi+1]};
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl5
        assign lvl5[gi] = {1'b0, lvl4[2*gi]} + {1'b0, lvl4[2*gi+1]};
    end

    assign count = {1'b0, lvl5[0]} + {1'b0, lvl5[1]};

endmodule
`endif

// File: rtl/lfsr64_checker.sv
// lfsr64_checker: receive-side checker for an lfsr64 state stream.
// Self-synchronises (SEARCH -> VERIFY -> LOCKED), then flywheels the
// prediction and counts every mispredicted word.
// Optional feature macro: LFSR_CHK_BITERR_EN adds bit_err_cnt, the saturating
// sum of differing bits over all mispredicted words while locked.
module lfsr64_checker
    import lfsr64_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8,
    parameter int ERR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       data_in,
    input  logic              valid_in,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic              zero_err,
`ifdef LFSR_CHK_BITERR_EN
    output logic [ERR_W-1:0]  bit_err_cnt,
`endif
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [7:0] LOSS_LAST = 8'(LOSS_CNT - 1);

    chk_state_t        state_reg, state_next;
    logic [63:0]       pred_reg, pred_next;
    logic [7:0]        match_cnt_reg, match_cnt_next;
    logic [7:0]        miss_cnt_reg, miss_cnt_next;
    logic [ERR_W-1:0]  err_cnt_reg, err_cnt_next;
    logic              locked_reg, locked_next;
    logic              err_pulse_reg, err_pulse_next;
    logic              zero_err_reg, zero_err_next;
    logic              mismatch;

    assign mismatch = (data_in != pred_reg);

`ifdef LFSR_CHK_BITERR_EN
    logic [ERR_W-1:0]  bit_err_cnt_reg, bit_err_cnt_next;
    logic [6:0]        diff_bits;
    logic [ERR_W:0]    bit_err_sum;

    popcount64 u_popcount (
        .din   (data_in ^ pred_reg),
        .count (diff_bits)
    );

    assign bit_err_sum = {1'b0, bit_err_cnt_reg} + (ERR_W+1)'(diff_bits);
`endif

    // State, predictor and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= SEARCH;
            pred_reg      <= '0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            zero_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pred_reg      <= pred_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
            zero_err_reg  <= zero_err_next;
        end
    end

`ifdef LFSR_CHK_BITERR_EN
    // Bit-error accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_err_cnt_reg <= '0;
        end else begin
            bit_err_cnt_reg <= bit_err_cnt_next;
        end
    end
`endif

    // Next-state logic: lock acquisition, flywheel prediction, error accounting.
    always_comb begin
        state_next     = state_reg;
        pred_next      = pred_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        err_cnt_next   = err_cnt_reg;
        err_pulse_next = 1'b0;
        zero_err_next  = 1'b0;
`ifdef LFSR_CHK_BITERR_EN
        bit_err_cnt_next = bit_err_cnt_reg;
`endif

        if (valid_in) begin
            unique case (state_reg)
                SEARCH: begin
                    if (data_in == '0) begin
                        zero_err_next = 1'b1;
                    end else begin
                        pred_next      = lfsr64_step(data_in);
                        match_cnt_next = '0;
                        state_next     = VERIFY;
                    end
                end
                VERIFY: begin
                    // Either way we reseed from the received word.
                    pred_next = lfsr64_step(data_in);
                    if (!mismatch) begin
                        match_cnt_next = match_cnt_reg + 8'd1;
                        if (match_cnt_reg == LOCK_LAST) begin
                            state_next    = LOCKED;
                            miss_cnt_next = '0;
                        end
                    end else begin
                        match_cnt_next = '0;
                        if (data_in == '0) begin
                            state_next    = SEARCH;
                            zero_err_next = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: advance from our own prediction, never from
                    // the received word, so one bad word costs one error.
                    pred_next = lfsr64_step(pred_reg);
                    if (mismatch) begin
                        err_pulse_next = 1'b1;
                        zero_err_next  = (data_in == '0);
                        if (err_cnt_reg != '1) begin
                            err_cnt_next = err_cnt_reg + ERR_W'(1);
                        end
`ifdef LFSR_CHK_BITERR_EN
                        bit_err_cnt_next = bit_err_sum[ERR_W] ? '1 : bit_err_sum[ERR_W-1:0];
`endif
                        if (miss_cnt_reg == LOSS_LAST) begin
                            state_next    = SEARCH;
                            miss_cnt_next = '0;
                        end else begin
                            miss_cnt_next = miss_cnt_reg + 8'd1;
                        end
                    end else begin
                        miss_cnt_next = '0;
                    end
                end
                default: begin
                    state_next = SEARCH;
                end
            endcase
        end

        // clear overrides any increment in the same cycle.
        if (clear) begin
            err_cnt_next = '0;
`ifdef LFSR_CHK_BITERR_EN
            bit_err_cnt_next = '0;
`endif
        end

        locked_next = (state_next == LOCKED);
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign zero_err  = zero_err_reg;
    assign err_cnt   = err_cnt_reg;
`ifdef LFSR_CHK_BITERR_EN
    assign bit_err_cnt = bit_err_cnt_reg;
`endif

endmodule

// File: tb/tb_lfsr64_checker.sv
// Testbench for lfsr64_checker: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the lock rules.
module tb_lfsr64_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 8;
    localparam int ERR_W    = 32;
    localparam longint ERR_MAX = (64'd1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [63:0]       data_in = '0;
    logic              valid_in = 1'b0;
    logic              clear = 1'b0;
    logic              locked;
    logic              err_pulse;
    logic              zero_err;
    logic [ERR_W-1:0]  err_cnt;
`ifdef LFSR_CHK_BITERR_EN
    logic [ERR_W-1:0]  bit_err_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state.
    int          m_mode;      // 0 searching, 1 verifying, 2 locked
    logic [63:0] m_pred;
    int          m_run;       // consecutive good predictions while verifying
    int          m_bad;       // consecutive bad words while locked
    longint      m_err;
    longint      m_bits;
    logic        m_pulse, m_zero;

    logic [63:0] gen;         // the generator-side stream

    lfsr64_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .ERR_W    (ERR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .zero_err  (zero_err),
`ifdef LFSR_CHK_BITERR_EN
        .bit_err_cnt (bit_err_cnt),
`endif
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_step(input logic [63:0] s);
        logic fb;
        fb = s[63] ^ s[62] ^ s[60] ^ s[59];
        return (s << 1) | {63'd0, fb};
    endfunction

    function automatic logic [63:0] next_gen();
        logic [63:0] w;
        w   = gen;
        gen = ref_step(gen);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pred = '0; m_run = 0; m_bad = 0;
        m_err = 0; m_bits = 0; m_pulse = 0; m_zero = 0;
    endtask

    // Apply the lock/error rules to one sampled input cycle.
    task automatic model_update(input logic v, input logic [63:0] d, input logic c);
        logic [63:0] expect_w;
        m_pulse = 0;
        m_zero  = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (d == 0) m_zero = 1;
                else begin m_pred = ref_step(d); m_run = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == m_pred) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
                end else begin
                    m_run = 0;
                    if (d == 0) begin m_mode = 0; m_zero = 1; end
                end
                m_pred = ref_step(d);
            end else begin
                expect_w = m_pred;
                m_pred   = ref_step(m_pred);
                if (d != expect_w) begin
                    m_pulse = 1;
                    m_zero  = (d == 0);
                    if (m_err < ERR_MAX) m_err++;
                    m_bits = m_bits + $countones(d ^ expect_w);
                    if (m_bits > ERR_MAX) m_bits = ERR_MAX;
                    m_bad++;
                    if (m_bad == LOSS_CNT) begin m_mode = 0; m_bad = 0; end
                end else begin
                    m_bad = 0;
                end
            end
        end
        if (c) begin m_err = 0; m_bits = 0; end
    endtask

    task automatic check_all();
        chk("locked",    {63'd0, locked},    {63'd0, m_mode == 2});
        chk("err_pulse", {63'd0, err_pulse}, {63'd0, m_pulse});
        chk("zero_err",  {63'd0, zero_err},  {63'd0, m_zero});
        chk("err_cnt",   64'(err_cnt),       64'(m_err));
`ifdef LFSR_CHK_BITERR_EN
        chk("bit_err_cnt", 64'(bit_err_cnt), 64'(m_bits));
`endif
    endtask

    // One clock cycle: drive on the falling edge, compare 1 ns after the rise.
    task automatic cycle(input logic v, input logic [63:0] d, input logic c);
        @(negedge clk);
        valid_in = v; data_in = d; clear = c;
        @(posedge clk);
        model_update(v, d, c);
        #1;
        check_all();
        $display("t=%0t v=%0b d=%016h clr=%0b -> locked=%0b pulse=%0b zero=%0b err_cnt=%0d",
                 $time, v, d, c, locked, err_pulse, zero_err, err_cnt);
    endtask

    initial begin
        logic [63:0] w;
        longint base;

        model_reset();
        #3 reset = 1'b0;
        #2;
        chk("rst_locked",    {63'd0, locked},    64'd0);
        chk("rst_err_pulse", {63'd0, err_pulse}, 64'd0);
        chk("rst_zero_err",  {63'd0, zero_err},  64'd0);
        chk("rst_err_cnt",   64'(err_cnt),       64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Lock on the stream seeded at 0x7A; first words are 7A, F4, 1E8...
        gen = 64'h7A;
        for (int i = 0; i < 4; i++) cycle(1'b1, next_gen(), 1'b0);
        chk("lock_4words", {63'd0, locked}, 64'd0);
        chk("seq_third", gen, 64'h7A0);
        cycle(1'b1, next_gen(), 1'b0);
        chk("lock_5words", {63'd0, locked}, 64'd1);
        for (int i = 5; i < 1000; i++) cycle(1'b1, next_gen(), 1'b0);
        chk("err_1000", 64'(err_cnt), 64'd0);

        // Single flipped bit: one error, flywheel holds.
        cycle(1'b1, next_gen() ^ 64'd1, 1'b0);
        chk("flip_pulse",  {63'd0, err_pulse}, 64'd1);
        chk("flip_errcnt", 64'(err_cnt), 64'd1);
        chk("flip_locked", {63'd0, locked}, 64'd1);
`ifdef LFSR_CHK_BITERR_EN
        chk("flip_biterr", 64'(bit_err_cnt), 64'd1);
`endif
        cycle(1'b1, next_gen(), 1'b0);
        chk("flip_next_ok", {63'd0, err_pulse}, 64'd0);

        // Random sparse corruptions with valid gaps.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 64'($urandom), 1'b0);
            else begin
                w = next_gen();
                if ($urandom_range(0, 9) == 0) w = w ^ (64'd1 << $urandom_range(0, 63));
                cycle(1'b1, w, 1'b0);
            end
        end

        // clear colliding with a mismatch at err_cnt = 5.
        cycle(1'b1, next_gen(), 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, next_gen() ^ 64'h100, 1'b0);
        chk("pre_clear_cnt", 64'(err_cnt), 64'd5);
        cycle(1'b1, next_gen() ^ 64'h3, 1'b1);
        chk("clear_cnt",   64'(err_cnt), 64'd0);
        chk("clear_pulse", {63'd0, err_pulse}, 64'd1);
        cycle(1'b1, next_gen(), 1'b0);

        // Eight garbage words drop lock.
        for (int i = 0; i < 7; i++) begin
            w = next_gen();
            cycle(1'b1, 64'hDEADBEEF, 1'b0);
        end
        chk("loss_7", {63'd0, locked}, 64'd1);
        w = next_gen();
        cycle(1'b1, 64'hDEADBEEF, 1'b0);
        chk("loss_8", {63'd0, locked}, 64'd0);
        chk("loss_errcnt", 64'(err_cnt), 64'd8);
        for (int i = 0; i < 4; i++) cycle(1'b1, next_gen(), 1'b0);
        chk("relock_4", {63'd0, locked}, 64'd0);
        cycle(1'b1, next_gen(), 1'b0);
        chk("relock_5", {63'd0, locked}, 64'd1);

        // Build err_cnt = 3 then assert reset between edges.
        cycle(1'b1, next_gen(), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, next_gen() ^ 64'h8000_0000_0000_0000, 1'b0);
        chk("pre_rst_cnt", 64'(err_cnt), 64'd3);
        @(negedge clk);
        valid_in = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_locked", {63'd0, locked}, 64'd0);
        chk("async_errcnt", 64'(err_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Zero word while searching.
        cycle(1'b1, 64'd0, 1'b0);
        chk("zero_search", {63'd0, zero_err}, 64'd1);
        chk("zero_locked", {63'd0, locked}, 64'd0);
        cycle(1'b0, 64'd0, 1'b0);
        chk("zero_gone", {63'd0, zero_err}, 64'd0);

        // Alternating valid: still exactly five valid words to lock.
        gen = 64'h1234_5678_9ABC_DEF1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, next_gen(), 1'b0);
            cycle(1'b0, 64'($urandom), 1'b0);
        end
        chk("alt_4", {63'd0, locked}, 64'd0);
        cycle(1'b1, next_gen(), 1'b0);
        chk("alt_5", {63'd0, locked}, 64'd1);

        // Randomized mix of corruptions, zeros, clears and gaps.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 15)      cycle(1'b0, 64'($urandom), 1'b0);
            else if (r < 20) begin w = next_gen(); cycle(1'b1, 64'd0, 1'b0); end
            else if (r < 30) cycle(1'b1, next_gen() ^ {32'($urandom), 32'($urandom)}, 1'b0);
            else if (r < 33) cycle(1'b1, next_gen(), 1'b1);
            else if (r < 35) begin gen = {32'($urandom), 32'($urandom)} | 64'd1; cycle(1'b1, next_gen(), 1'b0); end
            else             cycle(1'b1, next_gen(), 1'b0);
        end

        base = m_err;
        chk("final_cnt_model", 64'(err_cnt), 64'(base));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
